ps2_keycode_rx: RTL
===================

# ps2_keycode_rx

PS/2 keyboard receiver that turns the serial PS2_CLK/PS2_DAT pair into a held Set-2 make code on KEYCODE. It sits directly upstream of the keypress-to-direction stage, which samples KEYCODE whenever its GET_INPUT is low. KEYCODE therefore always holds the currently held key, or 8'h00 when no key is held. The block also performs clock-line filtering, frame checking and break/extended prefix decoding.

## Interface
- FILTER_LEN, 8: consecutive agreeing samples required before the filtered PS/2 clock changes level (≥2).
- TIMEOUT_CYCLES, 10000: CLOCK_50 cycles allowed between falling clock edges inside a frame (200 µs).
- CLOCK_50  in  1  system clock, 50 MHz
- RESET_N  in  1  asynchronous, active-low reset
- PS2_CLK  in  1  raw keyboard clock (asynchronous, idle high)
- PS2_DAT  in  1  raw keyboard data (asynchronous, idle high)
- KEYCODE  out  8  make code of held key, 8'h00 when none
- PRESSED  out  1  high while KEYCODE ≠ 8'h00
- KEY_VALID  out  1  one-cycle pulse on every accepted make code, including auto-repeat
- FRAME_ERR  out  1  one-cycle pulse on bad start, parity, stop or timeout

## Operation
- **Line conditioning**
  - PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser.
  - Synchronised clock feeds a FILTER_LEN-deep shift register. The filtered clock (reset 1) takes a new level only when all FILTER_LEN samples agree.
  - Fall strobe: filtered clock goes 1→0. Data is sampled from the synchronised PS2_DAT on the strobe.
- **Frame FSM** (IDLE, DATA, PARITY, STOP), advancing only on fall strobes:
  - IDLE: data=0 → DATA with bit count 0. Data=1 → stay; this is a spurious edge and raises no error.
  - DATA: shift the bit in at MSB, shifting right, so bits arrive LSB first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: byte is good iff stop=1 and the 8 data bits plus parity bit have odd parity. Good → byte strobe. Bad → FRAME_ERR. Either way → IDLE.
  - Timeout: counter clears on every fall strobe and is idle in IDLE. In a non-IDLE state, reaching TIMEOUT_CYCLES−1 → IDLE, FRAME_ERR pulse, partial byte discarded.
- **Decoder**, acting on byte strobes. Flags brk and ext reset to 0 and are cleared by FRAME_ERR.
  - 8'hF0 → brk=1. 8'hE0 → ext=1.
  - 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF → ignored; flags unchanged.
  - Other byte b with ext=1 → ignored; clear brk and ext.
  - Other byte b with brk=1 → if b==KEYCODE, KEYCODE←8'h00. Clear brk.
  - Other byte b, neither flag set → KEYCODE←b, KEY_VALID pulse.
  - Newest make wins. Releasing a key that is not the one in KEYCODE leaves KEYCODE unchanged.
- PRESSED is registered together with KEYCODE.

## Timing
- **Reset (async assert, sync release):**
  - KEYCODE=8'h00, PRESSED=0, KEY_VALID=0, FRAME_ERR=0.
  - FSM=IDLE, synchronisers=1, filter=all 1, filtered clock=1, flags=0, timeout counter=0.
- **Pipeline:** synchroniser 2 cycles, filter FILTER_LEN cycles, filtered-clock register 1 cycle, FSM/decoder register 1 cycle.
- **Latency:** KEYCODE, KEY_VALID and FRAME_ERR change exactly FILTER_LEN+4 CLOCK_50 cycles after PS2_CLK falls for the stop bit (or after the timeout count expires, for timeout).
- **Pulse width:** KEY_VALID and FRAME_ERR are exactly 1 cycle. They are never asserted together.
- **Glitches:** clock pulses shorter than FILTER_LEN cycles produce no strobe.
- **Reset mid-frame:** partial frame discarded. Next frame is received normally from its start bit.
- **KEYCODE stability:** KEYCODE changes at most once per received byte and is otherwise stable, so the downstream stage may sample it on any cycle.

## Structure
- Package ps2_pkg holds:
  - frame-state enum ps2_state_t (IDLE, DATA, PARITY, STOP);
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_NOKEY=8'h00.
- One sub-module, ps2_line_filter: synchronisers, clock glitch filter, fall strobe and synchronised data output. The top level holds the frame FSM, timeout counter and decoder.
- Receive only; no host-to-device transmit.

## Test plan
- Frame 8'h1D, odd parity, ~12 kHz bit rate → KEYCODE=8'h1D, PRESSED=1 and one KEY_VALID pulse, exactly FILTER_LEN+4 cycles after the stop-bit fall.
- Bytes 1D, F0, 1D → KEYCODE 1D then 00. KEY_VALID pulses once. PRESSED ends 0.
- Bytes 1C, 23, F0 1C → KEYCODE ends 23. Then F0 23 → 00.
- Frame 8'h1B with a wrong parity bit → FRAME_ERR pulse, KEYCODE unchanged. A following good 8'h1B → KEYCODE=8'h1B.
- Bytes E0, 75 (extended up) and AA → KEYCODE stays 00, no KEY_VALID. Stop PS2_CLK after 4 data bits → FRAME_ERR after TIMEOUT_CYCLES. The next full frame decodes correctly.
- 3-cycle low glitches on PS2_CLK during idle → no state change. RESET_N pulsed mid-frame after 1D is held → KEYCODE=00 immediately; next frame decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and reserved byte values for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_NOKEY  = 8'h00;
   localparam logic [7:0] PS2_OVF    = 8'hFF;

   function automatic logic is_ignored(input logic [7:0] b);
      return (b == PS2_BAT) || (b == PS2_ACK) ||
             (b == PS2_RESEND) || (b == PS2_NOKEY) ||
             (b == PS2_OVF);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 lines, deglitches the clock and
// emits a one-cycle strobe on each filtered falling edge.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic fall,
   output logic dat
);

   logic [1:0]            clk_sync;
   logic [1:0]            dat_sync;
   logic [FILTER_LEN-1:0] hist;
   logic                  filt;
   logic                  all_hi;
   logic                  all_lo;

   assign all_hi = &hist;
   assign all_lo = ~|hist;
   assign dat    = dat_sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         hist     <= '1;
         filt     <= 1'b1;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
         hist     <= {hist[FILTER_LEN-2:0], clk_sync[1]};
         fall     <= filt & all_lo;
         if (all_hi)
            filt <= 1'b1;
         else if (all_lo)
            filt <= 1'b0;
      end
   end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 Set-2 receiver: frame FSM, timeout and make/break
// decoding into a held KEYCODE.
module ps2_keycode_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] KEYCODE,
   output logic       PRESSED,
   output logic       KEY_VALID,
   output logic       FRAME_ERR
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_MAX =
      TO_W'(TIMEOUT_CYCLES - 1);

   logic            fall;
   logic            dat;
   ps2_state_t      state;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            par;
   logic [TO_W-1:0] to_cnt;
   logic            brk;
   logic            ext;
   logic            good;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_filter (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .ps2_clk(PS2_CLK),
      .ps2_dat(PS2_DAT),
      .fall   (fall),
      .dat    (dat)
   );

   // Stop bit high and odd parity over data plus parity bit.
   assign good = dat & (^{shreg, par});

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par       <= 1'b0;
         to_cnt    <= '0;
         brk       <= 1'b0;
         ext       <= 1'b0;
         KEYCODE   <= PS2_NOKEY;
         PRESSED   <= 1'b0;
         KEY_VALID <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         KEY_VALID <= 1'b0;
         FRAME_ERR <= 1'b0;
         if (state == IDLE || fall)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;

         if (state != IDLE && !fall && to_cnt == TO_MAX) begin
            state     <= IDLE;
            FRAME_ERR <= 1'b1;
            brk       <= 1'b0;
            ext       <= 1'b0;
         end else if (fall) begin
            unique case (state)
               IDLE: begin
                  if (!dat) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg   <= {dat, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7)
                     state <= PARITY;
               end
               PARITY: begin
                  par   <= dat;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (!good) begin
                     FRAME_ERR <= 1'b1;
                     brk       <= 1'b0;
                     ext       <= 1'b0;
                  end else if (shreg == PS2_BREAK) begin
                     brk <= 1'b1;
                  end else if (shreg == PS2_EXT) begin
                     ext <= 1'b1;
                  end else if (!is_ignored(shreg)) begin
                     if (ext) begin
                        brk <= 1'b0;
                        ext <= 1'b0;
                     end else if (brk) begin
                        brk <= 1'b0;
                        if (shreg == KEYCODE) begin
                           KEYCODE <= PS2_NOKEY;
                           PRESSED <= 1'b0;
                        end
                     end else begin
                        KEYCODE   <= shreg;
                        PRESSED   <= 1'b1;
                        KEY_VALID <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
